// File: rtl/sumador_pkg.sv
// ============================================================================
// Module  : sumador_pkg
// Brief   : Shared types and elaboration helpers for the digit-serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sumador_pkg;

    typedef enum logic [0:0] {
        REPOSO  = 1'b0,
        CALCULO = 1'b1
    } estado_t;

    // Returns the digit-cycle count, or 0 when the (W, D) pair is illegal.
    function automatic int calc_n(input int w, input int d);
        if (w < 2 || d < 1 || d > w || (w % d) != 0) begin
            return 0;
        end
        return w / d;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sumador_digito.sv
// ============================================================================
// Module  : sumador_digito
// Brief   : Combinational D-bit adder slice with a tap on the carry into its MSB.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sumador_digito #(
    parameter int D = 2
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         cin,
    output logic [D-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    generate
        if (D == 1) begin : g_un_bit
            assign cmsb = cin;
        end else begin : g_multi_bit
            logic [D-1:0] w_low;
            // Low D-1 bits summed with one spare bit so the MSB carry-in falls out.
            assign w_low       = {1'b0, a[D-2:0]} + {1'b0, b[D-2:0]} + {{(D-1){1'b0}}, cin};
            assign cmsb        = w_low[D-1];
            assign s[D-2:0]    = w_low[D-2:0];
        end
    endgenerate

    assign s[D-1] = a[D-1] ^ b[D-1] ^ cmsb;
    assign cout   = (a[D-1] & b[D-1]) | (cmsb & (a[D-1] ^ b[D-1]));

endmodule

`default_nettype wire

// File: rtl/sumador_serie_param.sv
// ============================================================================
// Module  : sumador_serie_param
// Brief   : Digit-serial W-bit adder, D bits per clock, start/valid handshake.
//           SUMADOR_SIGNO_EN adds Signo/Desborde for two's-complement operands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sumador_serie_param
    import sumador_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         Reloj,
    input  logic         Reset,
    input  logic         Inicio,
    input  logic [W-1:0] SumandoA,
    input  logic [W-1:0] SumandoB,
`ifdef SUMADOR_SIGNO_EN
    input  logic         Signo,
    output logic         Desborde,
`endif
    output logic [W:0]   Suma,
    output logic         Valido,
    output logic         Ocupado
);

    localparam int                c_N    = calc_n(W, D);
    localparam int                c_CW   = cnt_width(c_N);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(c_N - 1);

    generate
        if (c_N == 0) begin : g_param_error
            $error("sumador_serie_param: W must be >= 2 and a multiple of D, with 1 <= D <= W");
        end
    endgenerate

    estado_t         state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            carry_q, carry_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [W:0]      suma_q, suma_d;
    logic            valido_q, valido_d;

    logic [D-1:0]    w_dig_s;
    logic            w_dig_cout;
    logic            w_dig_cmsb;
    logic [W+D-1:0]  w_cat;
    logic [W-1:0]    w_acc_next;
    logic            w_msb;
    logic            w_unused_bits;

    sumador_digito #(
        .D    (D)
    ) u_digito (
        .a    (a_q[D-1:0]),
        .b    (b_q[D-1:0]),
        .cin  (carry_q),
        .s    (w_dig_s),
        .cout (w_dig_cout),
        .cmsb (w_dig_cmsb)
    );

    // New digit enters at the top; after N digits the LSD has reached bit 0.
    assign w_cat         = {w_dig_s, acc_q};
    assign w_acc_next    = w_cat[W+D-1:D];
    assign w_unused_bits = ^w_cat[D-1:0];

`ifdef SUMADOR_SIGNO_EN
    logic signo_q, signo_d;
    logic desborde_q, desborde_d;
    logic w_ovf;

    // On the last digit the operand MSBs sit at bit D-1 of the shift registers.
    assign w_msb = signo_q ? (a_q[D-1] ^ b_q[D-1] ^ w_dig_cout) : w_dig_cout;
    assign w_ovf = signo_q ? (w_dig_cmsb ^ w_dig_cout) : w_dig_cout;
`else
    logic w_unused_cmsb;

    assign w_msb         = w_dig_cout;
    assign w_unused_cmsb = w_dig_cmsb;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        suma_d   = suma_q;
        valido_d = 1'b0;
`ifdef SUMADOR_SIGNO_EN
        signo_d    = signo_q;
        desborde_d = desborde_q;
`endif
        case (state_q)
            REPOSO: begin
                if (Inicio) begin
                    state_d = CALCULO;
                    a_d     = SumandoA;
                    b_d     = SumandoB;
                    carry_d = 1'b0;
                    cnt_d   = '0;
`ifdef SUMADOR_SIGNO_EN
                    signo_d = Signo;
`endif
                end
            end
            CALCULO: begin
                a_d     = a_q >> D;
                b_d     = b_q >> D;
                acc_d   = w_acc_next;
                carry_d = w_dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    suma_d   = {w_msb, w_acc_next};
                    valido_d = 1'b1;
                    state_d  = REPOSO;
`ifdef SUMADOR_SIGNO_EN
                    desborde_d = w_ovf;
`endif
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge Reloj) begin
        if (Reset) begin
            state_q  <= REPOSO;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            suma_q   <= '0;
            valido_q <= 1'b0;
`ifdef SUMADOR_SIGNO_EN
            signo_q    <= 1'b0;
            desborde_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            suma_q   <= suma_d;
            valido_q <= valido_d;
`ifdef SUMADOR_SIGNO_EN
            signo_q    <= signo_d;
            desborde_q <= desborde_d;
`endif
        end
    end

    assign Suma    = suma_q;
    assign Valido  = valido_q;
    assign Ocupado = (state_q == CALCULO);
`ifdef SUMADOR_SIGNO_EN
    assign Desborde = desborde_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sumador_serie_param.sv
// ============================================================================
// Module  : tb_sumador_serie_param
// Brief   : Self-checking bench for sumador_serie_param (vector table + scoreboard).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sumador_serie_param;

    localparam int c_N = 4;

    typedef struct {
        logic [8:0] suma;
        logic       desb;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] suma;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio;
    logic [7:0] op_a, op_b;
    logic       signo;
    logic [8:0] suma;
    logic       valido, ocupado;
`ifdef SUMADOR_SIGNO_EN
    logic       desborde;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sumador_serie_param #(.W(8), .D(2)) u_dut (
        .Reloj    (clk),
        .Reset    (rst),
        .Inicio   (inicio),
        .SumandoA (op_a),
        .SumandoB (op_b),
`ifdef SUMADOR_SIGNO_EN
        .Signo    (signo),
        .Desborde (desborde),
`endif
        .Suma     (suma),
        .Valido   (valido),
        .Ocupado  (ocupado)
    );

    // Parameter sweep instances share one start strobe.
    logic        sw_start;
    logic [7:0]  sw_a, sw_b;
    logic [15:0] sw_a16, sw_b16;
    logic [8:0]  s1_suma, s8_suma;
    logic [16:0] s16_suma;
    logic        s1_val, s8_val, s16_val, s1_ocu, s8_ocu, s16_ocu;
`ifdef SUMADOR_SIGNO_EN
    logic        s1_des, s8_des, s16_des;
`endif

    sumador_serie_param #(.W(8), .D(1)) u_sw1 (
        .Reloj (clk), .Reset (rst), .Inicio (sw_start), .SumandoA (sw_a), .SumandoB (sw_b),
`ifdef SUMADOR_SIGNO_EN
        .Signo (1'b0), .Desborde (s1_des),
`endif
        .Suma (s1_suma), .Valido (s1_val), .Ocupado (s1_ocu)
    );

    sumador_serie_param #(.W(8), .D(8)) u_sw8 (
        .Reloj (clk), .Reset (rst), .Inicio (sw_start), .SumandoA (sw_a), .SumandoB (sw_b),
`ifdef SUMADOR_SIGNO_EN
        .Signo (1'b0), .Desborde (s8_des),
`endif
        .Suma (s8_suma), .Valido (s8_val), .Ocupado (s8_ocu)
    );

    sumador_serie_param #(.W(16), .D(4)) u_sw16 (
        .Reloj (clk), .Reset (rst), .Inicio (sw_start), .SumandoA (sw_a16), .SumandoB (sw_b16),
`ifdef SUMADOR_SIGNO_EN
        .Signo (1'b0), .Desborde (s16_des),
`endif
        .Suma (s16_suma), .Valido (s16_val), .Ocupado (s16_ocu)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_sum(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t       r;
        logic [8:0] sx;
        if (s) begin
            sx     = {a[7], a} + {b[7], b};
            r.suma = sx;
            r.desb = (a[7] == b[7]) && (sx[7] != a[7]);
        end else begin
            r.suma = {1'b0, a} + {1'b0, b};
            r.desb = r.suma[8];
        end
        return r;
    endfunction

    // Scoreboard: expectation pushed on the accepting edge, popped when the result is due.
    exp_t       sb_q[$];
    int         m_left  = 0;
    logic       m_valid = 1'b0;
    logic [8:0] m_suma  = '0;
    logic       m_desb  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_suma  <= '0;
            m_desb  <= 1'b0;
            sb_q.delete();
        end else begin
            m_valid <= 1'b0;
            if (m_left == 0) begin
                if (inicio) begin
                    sb_q.push_back(ref_sum(op_a, op_b, signo));
                    m_left <= c_N;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    if (sb_q.size() > 0) begin
                        m_suma <= sb_q[0].suma;
                        m_desb <= sb_q[0].desb;
                        void'(sb_q.pop_front());
                    end
                    m_valid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ocupado", ocupado, (m_left != 0));
        check("valido", valido, m_valid);
        check("suma", suma, m_suma);
`ifdef SUMADOR_SIGNO_EN
        check("desborde", desborde, m_desb);
`endif
    end

    task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [8:0] exp_s, input logic exp_d);
        int lat;
        lat    = 0;
        op_a   = a;
        op_b   = b;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        op_a   = 8'($urandom);
        op_b   = 8'($urandom);
        while (!valido && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, c_N);
        check({name, " suma"}, suma, exp_s);
`ifdef SUMADOR_SIGNO_EN
        check({name, " desborde"}, desborde, exp_d);
`else
        if (exp_d === 1'bx) $display("note: %s has no overflow expectation", name);
`endif
    endtask

    vec_t vt[8];

    initial begin
        int n_val;
        int lat1, lat8, lat16;
        logic [8:0]  r1, r8;
        logic [16:0] r16;

        rst      = 1'b1;
        inicio   = 1'b0;
        op_a     = '0;
        op_b     = '0;
        signo    = 1'b0;
        sw_start = 1'b0;
        sw_a     = '0;
        sw_b     = '0;
        sw_a16   = '0;
        sw_b16   = '0;

        vt[0] = '{8'hFF, 8'h01, 9'h100};
        vt[1] = '{8'h00, 8'h00, 9'h000};
        vt[2] = '{8'hA5, 8'h5A, 9'h0FF};
        vt[3] = '{8'hFF, 8'hFF, 9'h1FE};
        vt[4] = '{8'h80, 8'h80, 9'h100};
        vt[5] = '{8'h7F, 8'h01, 9'h080};
        vt[6] = '{8'h01, 8'hFE, 9'h0FF};
        vt[7] = '{8'h3C, 8'h0F, 9'h04B};

        repeat (2) @(negedge clk);
        check("reset suma", suma, 9'h000);
        check("reset valido", valido, 1'b0);
        check("reset ocupado", ocupado, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Each vector starts in the Valido cycle of the previous one.
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].suma, vt[i].suma[8]);
        end

        // Inicio held high: one accept every N+1 edges, busy-time starts ignored.
        n_val  = 0;
        inicio = 1'b1;
        for (int i = 0; i < 30; i++) begin
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            @(negedge clk);
            if (valido) n_val++;
        end
        inicio = 1'b0;
        check("back-to-back results", n_val, 6);
        repeat (2) @(negedge clk);

        // Reset on the second CALCULO edge discards the addition.
        op_a   = 8'hFF;
        op_b   = 8'hFF;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort suma", suma, 9'h000);
        check("abort ocupado", ocupado, 1'b0);
        check("abort valido", valido, 1'b0);
        n_val = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valido) n_val++;
        end
        check("abort no valido", n_val, 0);
        run_vec("after abort", 8'h10, 8'h20, 9'h030, 1'b0);
        @(negedge clk);

`ifdef SUMADOR_SIGNO_EN
        signo = 1'b1;
        run_vec("signed 7F+01", 8'h7F, 8'h01, 9'h080, 1'b1);
        run_vec("signed 80+80", 8'h80, 8'h80, 9'h100, 1'b1);
        run_vec("signed FF+01", 8'hFF, 8'h01, 9'h000, 1'b0);
        run_vec("signed C0+F0", 8'hC0, 8'hF0, 9'h1B0, 1'b0);
        signo = 1'b0;
        run_vec("unsigned FF+01", 8'hFF, 8'h01, 9'h100, 1'b1);
        @(negedge clk);
`endif

        // Sweep (8,1), (8,8), (16,4) with random operands.
        for (int it = 0; it < 1000; it++) begin
            sw_a     = 8'($urandom);
            sw_b     = 8'($urandom);
            sw_a16   = 16'($urandom);
            sw_b16   = 16'($urandom);
            sw_start = 1'b1;
            @(negedge clk);
            sw_start = 1'b0;
            lat1  = -1;
            lat8  = -1;
            lat16 = -1;
            r1    = '0;
            r8    = '0;
            r16   = '0;
            for (int k = 0; k <= 10; k++) begin
                if (s1_val && lat1 < 0) begin
                    lat1 = k;
                    r1   = s1_suma;
                end
                if (s8_val && lat8 < 0) begin
                    lat8 = k;
                    r8   = s8_suma;
                end
                if (s16_val && lat16 < 0) begin
                    lat16 = k;
                    r16   = s16_suma;
                end
                @(negedge clk);
            end
            check("sweep8x1 latency", lat1, 8);
            check("sweep8x1 suma", r1, {1'b0, sw_a} + {1'b0, sw_b});
            check("sweep8x8 latency", lat8, 1);
            check("sweep8x8 suma", r8, {1'b0, sw_a} + {1'b0, sw_b});
            check("sweep16x4 latency", lat16, 4);
            check("sweep16x4 suma", r16, {1'b0, sw_a16} + {1'b0, sw_b16});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
